// File: rtl/multi_timer_pkg.sv
// Shared types and BCD helpers for the multi-channel countdown timer.
// Used by multi_timer (top) and timer_channel (per-channel FSM).
package multi_timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    ALARM
  } timer_state_t;

  typedef enum logic [1:0] {
    F_SEC,
    F_MIN,
    F_HOUR
  } field_t;

  typedef struct packed {
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] s;
  } bcd_time_t;

  localparam logic [7:0] BCD_59 = 8'h59;
  localparam logic [7:0] BCD_23 = 8'h23;

  // Two-digit BCD +1, wrapping to 00 once lim is reached.
  function automatic logic [7:0] bcd_inc_wrap(
    input logic [7:0] v,
    input logic [7:0] lim
  );
    logic [7:0] r;
    if (v >= lim)
      r = 8'h00;
    else if (v[3:0] == 4'h9)
      r = {v[7:4] + 4'h1, 4'h0};
    else
      r = {v[7:4], v[3:0] + 4'h1};
    return r;
  endfunction

  // Two-digit BCD -1 for a nonzero value.
  function automatic logic [7:0] bcd_dec8(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'h0)
      r = {v[7:4] - 4'h1, 4'h9};
    else
      r = {v[7:4], v[3:0] - 4'h1};
    return r;
  endfunction

  // HH:MM:SS -1 with borrow. Hours wrap to 23 so
  // digits stay legal even if called at zero.
  function automatic bcd_time_t bcd_dec_borrow(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.s != 8'h00) begin
      r.s = bcd_dec8(t.s);
    end else begin
      r.s = BCD_59;
      if (t.m != 8'h00) begin
        r.m = bcd_dec8(t.m);
      end else begin
        r.m = BCD_59;
        r.h = (t.h != 8'h00) ? bcd_dec8(t.h) : BCD_23;
      end
    end
    return r;
  endfunction

  // Increment one field, no carry into neighbours.
  function automatic bcd_time_t bcd_inc_field(
    input bcd_time_t t,
    input field_t    f
  );
    bcd_time_t r;
    r = t;
    unique case (f)
      F_SEC:   r.s = bcd_inc_wrap(t.s, BCD_59);
      F_MIN:   r.m = bcd_inc_wrap(t.m, BCD_59);
      F_HOUR:  r.h = bcd_inc_wrap(t.h, BCD_23);
      default: r = t;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: IDLE/RUN/PAUSE/ALARM FSM, preset, count, alarm timer.
// Ports: clock, reset, sec_tick, clr/run/inc (already gated), field, count, running, alarm.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int ALARM_SECS = 10
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      sec_tick,
  input  logic      clr,
  input  logic      run,
  input  logic      inc,
  input  field_t    field,
  output bcd_time_t count,
  output logic      running,
  output logic      alarm
);

  localparam int AW =
    (ALARM_SECS > 0) ? $clog2(ALARM_SECS + 1) : 1;

  timer_state_t state;
  bcd_time_t    preset;
  bcd_time_t    edited;
  logic [AW-1:0] acnt;

  assign edited = bcd_inc_field(count, field);

  // running/alarm are set alongside each state change
  // so they mirror the registered state exactly.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      preset  <= '0;
      count   <= '0;
      acnt    <= '0;
      running <= 1'b0;
      alarm   <= 1'b0;
    end else if (clr) begin
      state   <= IDLE;
      count   <= preset;
      running <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (run) begin
            if (count != '0) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end else if (inc) begin
            // count tracks preset while idle
            preset <= edited;
            count  <= edited;
          end
        end
        RUN: begin
          if (run) begin
            state   <= PAUSE;
            running <= 1'b0;
          end else if (sec_tick) begin
            count <= bcd_dec_borrow(count);
            if (count == 24'h000001) begin
              state   <= ALARM;
              running <= 1'b0;
              alarm   <= 1'b1;
              acnt    <= AW'(ALARM_SECS);
            end
          end
        end
        PAUSE: begin
          if (run) begin
            state   <= RUN;
            running <= 1'b1;
          end else if (inc) begin
            count <= edited;
          end
        end
        ALARM: begin
          if (run || (sec_tick && acnt <= AW'(1))) begin
            state <= IDLE;
            count <= preset;
            alarm <= 1'b0;
          end else if (sec_tick) begin
            acnt <= acnt - 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          alarm   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/multi_timer.sv
// Bank of CHANNELS HH:MM:SS countdown timers with shared prescaler and selection.
// Ports: clock, reset, active, *_pulse buttons; disp_data/disp_chan/edit_field, running, alarm.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int CLK_HZ     = 50_000_000,
  parameter int ALARM_SECS = 10,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                active,
  input  logic                sel_pulse,
  input  logic                field_pulse,
  input  logic                inc_pulse,
  input  logic                run_pulse,
  input  logic                clr_pulse,
  output logic [23:0]         disp_data,
  output logic [CW-1:0]       disp_chan,
  output logic [1:0]          edit_field,
  output logic [CHANNELS-1:0] running,
  output logic [CHANNELS-1:0] alarm
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [PW-1:0] pre;
  logic          sec_tick;
  field_t        field;

  logic do_clr;
  logic do_run;
  logic do_inc;
  logic do_fld;

  logic [CHANNELS-1:0] hit;
  bcd_time_t           counts [CHANNELS];

  assign sec_tick = (pre == PW'(CLK_HZ - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      pre <= '0;
    else
      pre <= sec_tick ? '0 : pre + 1'b1;
  end

  // One winning action per cycle: clr > run > inc > field.
  assign do_clr = active & clr_pulse;
  assign do_run = active & run_pulse & ~clr_pulse;
  assign do_inc = active & inc_pulse & ~clr_pulse
                & ~run_pulse;
  assign do_fld = active & field_pulse & ~clr_pulse
                & ~run_pulse & ~inc_pulse;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      disp_chan <= '0;
      field     <= F_SEC;
    end else begin
      if (active && sel_pulse)
        disp_chan <= (disp_chan == CW'(CHANNELS - 1))
                   ? '0 : disp_chan + 1'b1;
      if (do_fld) begin
        unique case (field)
          F_SEC:   field <= F_MIN;
          F_MIN:   field <= F_HOUR;
          default: field <= F_SEC;
        endcase
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign hit[i] = (disp_chan == CW'(i));

    timer_channel #(
      .ALARM_SECS(ALARM_SECS)
    ) u_ch (
      .clock    (clock),
      .reset    (reset),
      .sec_tick (sec_tick),
      .clr      (do_clr & hit[i]),
      .run      (do_run & hit[i]),
      .inc      (do_inc & hit[i]),
      .field    (field),
      .count    (counts[i]),
      .running  (running[i]),
      .alarm    (alarm[i])
    );
  end

  assign disp_data  = counts[disp_chan];
  assign edit_field = field;

endmodule

// File: tb/tb_multi_timer.sv
// Testbench for multi_timer: directed vector table, hand sequences,
// and randomized pulses checked against a seconds-based reference model.
module tb_multi_timer;

  localparam int CH = 4;
  localparam int HZ = 4;
  localparam int AS = 3;

  localparam logic [4:0] P_SEL = 5'b10000;
  localparam logic [4:0] P_FLD = 5'b01000;
  localparam logic [4:0] P_INC = 5'b00100;
  localparam logic [4:0] P_RUN = 5'b00010;
  localparam logic [4:0] P_CLR = 5'b00001;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_ALARM = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic active = 1'b0;
  logic sel_pulse = 1'b0;
  logic field_pulse = 1'b0;
  logic inc_pulse = 1'b0;
  logic run_pulse = 1'b0;
  logic clr_pulse = 1'b0;
  logic [23:0] disp_data;
  logic [1:0]  disp_chan;
  logic [1:0]  edit_field;
  logic [3:0]  running;
  logic [3:0]  alarm;

  always #5 clock = ~clock;

  multi_timer #(
    .CHANNELS(CH),
    .CLK_HZ(HZ),
    .ALARM_SECS(AS)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .active      (active),
    .sel_pulse   (sel_pulse),
    .field_pulse (field_pulse),
    .inc_pulse   (inc_pulse),
    .run_pulse   (run_pulse),
    .clr_pulse   (clr_pulse),
    .disp_data   (disp_data),
    .disp_chan   (disp_chan),
    .edit_field  (edit_field),
    .running     (running),
    .alarm       (alarm)
  );

  int total = 0;
  int bad = 0;

  // reference model: times held as plain seconds
  int ppos;
  int tcnt;
  int mchan;
  int mfield;
  int mst   [CH];
  int mcnt  [CH];
  int mpset [CH];
  int marem [CH];

  typedef struct {
    logic        act;
    logic [4:0]  p;
    int          reps;
    int          ticks;
    bit          align;
    logic [23:0] d;
    logic [1:0]  ch;
    logic [1:0]  fl;
    logic [3:0]  r;
    logic [3:0]  a;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] b2(input int x);
    return 8'(((x / 10) * 16) + (x % 10));
  endfunction

  function automatic logic [23:0] to_bcd(input int secs);
    return {b2(secs / 3600), b2((secs / 60) % 60), b2(secs % 60)};
  endfunction

  function automatic int incf(input int secs, input int f);
    int h, m, s;
    h = secs / 3600;
    m = (secs / 60) % 60;
    s = secs % 60;
    if (f == 0) s = (s + 1) % 60;
    else if (f == 1) m = (m + 1) % 60;
    else h = (h + 1) % 24;
    return h * 3600 + m * 60 + s;
  endfunction

  task automatic model_reset();
    ppos = 0;
    mchan = 0;
    mfield = 0;
    for (int c = 0; c < CH; c++) begin
      mst[c] = S_IDLE;
      mcnt[c] = 0;
      mpset[c] = 0;
      marem[c] = 0;
    end
  endtask

  task automatic model_edge(input logic a, input logic [4:0] p);
    bit tick, me, cl, rn, in1;
    tick = (ppos == HZ - 1);
    ppos = (ppos + 1) % HZ;
    if (tick) tcnt++;
    for (int c = 0; c < CH; c++) begin
      me  = a && (c == mchan);
      cl  = me && p[0];
      rn  = me && p[1] && !p[0];
      in1 = me && p[2] && !p[1] && !p[0];
      if (cl) begin
        mst[c] = S_IDLE;
        mcnt[c] = mpset[c];
      end else begin
        case (mst[c])
          S_IDLE: begin
            if (rn) begin
              if (mcnt[c] != 0) mst[c] = S_RUN;
            end else if (in1) begin
              mcnt[c] = incf(mcnt[c], mfield);
              mpset[c] = mcnt[c];
            end
          end
          S_RUN: begin
            if (rn) mst[c] = S_PAUSE;
            else if (tick) begin
              mcnt[c]--;
              if (mcnt[c] == 0) begin
                mst[c] = S_ALARM;
                marem[c] = AS;
              end
            end
          end
          S_PAUSE: begin
            if (rn) mst[c] = S_RUN;
            else if (in1) mcnt[c] = incf(mcnt[c], mfield);
          end
          default: begin
            if (rn) begin
              mst[c] = S_IDLE;
              mcnt[c] = mpset[c];
            end else if (tick) begin
              marem[c]--;
              if (marem[c] == 0) begin
                mst[c] = S_IDLE;
                mcnt[c] = mpset[c];
              end
            end
          end
        endcase
      end
    end
    if (a && p[3] && !p[2] && !p[1] && !p[0])
      mfield = (mfield + 1) % 3;
    if (a && p[4])
      mchan = (mchan + 1) % CH;
  endtask

  task automatic model_check(input int n);
    logic [3:0] er, ea;
    for (int c = 0; c < CH; c++) begin
      er[c] = (mst[c] == S_RUN);
      ea[c] = (mst[c] == S_ALARM);
    end
    chk($sformatf("r%0d_data", n), disp_data, to_bcd(mcnt[mchan]));
    chk($sformatf("r%0d_chan", n), disp_chan, 32'(mchan));
    chk($sformatf("r%0d_field", n), edit_field, 32'(mfield));
    chk($sformatf("r%0d_running", n), running, er);
    chk($sformatf("r%0d_alarm", n), alarm, ea);
  endtask

  task automatic step(input logic a, input logic [4:0] p);
    active = a;
    {sel_pulse, field_pulse, inc_pulse, run_pulse, clr_pulse} = p;
    @(posedge clock);
    model_edge(a, p);
    #1;
    {sel_pulse, field_pulse, inc_pulse, run_pulse, clr_pulse} = '0;
  endtask

  task automatic wait_ticks(input string nm, input int need);
    tcnt = 0;
    for (int k = 0; k < HZ * (need + 1) && tcnt < need; k++)
      step(1'b1, '0);
    if (tcnt < need) begin
      total++;
      bad++;
      $display("FAIL %s tick wait expired got=%0d exp=%0d", nm, tcnt, need);
    end
  endtask

  task automatic add(input logic a, input logic [4:0] p, input int reps,
                     input int ticks, input bit al, input logic [23:0] d,
                     input logic [1:0] ch, input logic [1:0] fl,
                     input logic [3:0] r, input logic [3:0] am);
    tbl.push_back('{a, p, reps, ticks, al, d, ch, fl, r, am});
  endtask

  initial begin
    // act  pulses       reps tk al data        ch fl run  alarm
    add(1, P_FLD,         2,  0, 0, 24'h000000, 0, 2, 0, 0);
    add(1, P_INC,        25,  0, 0, 24'h010000, 0, 2, 0, 0);
    add(1, P_FLD,         1,  0, 0, 24'h010000, 0, 0, 0, 0);
    add(1, P_INC,        60,  0, 0, 24'h010000, 0, 0, 0, 0);
    add(1, P_FLD,         2,  0, 0, 24'h010000, 0, 2, 0, 0);
    add(1, P_INC,        23,  0, 0, 24'h000000, 0, 2, 0, 0);
    add(1, P_FLD,         2,  0, 0, 24'h000000, 0, 1, 0, 0);
    add(1, P_INC,         1,  0, 0, 24'h000100, 0, 1, 0, 0);
    add(1, P_RUN,         1,  0, 0, 24'h000100, 0, 1, 1, 0);
    add(1, '0,            0,  1, 0, 24'h000059, 0, 1, 1, 0);
    add(1, '0,            0, 59, 0, 24'h000000, 0, 1, 0, 1);
    add(1, '0,            0,  2, 0, 24'h000000, 0, 1, 0, 1);
    add(1, '0,            0,  1, 0, 24'h000100, 0, 1, 0, 0);
    add(1, P_RUN,         1,  0, 0, 24'h000100, 0, 1, 1, 0);
    add(1, '0,            0, 60, 0, 24'h000000, 0, 1, 0, 1);
    add(1, P_RUN,         1,  0, 0, 24'h000100, 0, 1, 0, 0);
    add(1, P_INC,        59,  0, 0, 24'h000000, 0, 1, 0, 0);
    add(1, P_FLD,         2,  0, 0, 24'h000000, 0, 0, 0, 0);
    add(1, P_INC,         5,  0, 0, 24'h000005, 0, 0, 0, 0);
    add(1, P_RUN,         1,  0, 0, 24'h000005, 0, 0, 1, 0);
    add(1, P_SEL,         1,  5, 1, 24'h000000, 1, 0, 0, 1);
    add(1, P_SEL,         3,  0, 0, 24'h000000, 0, 0, 0, 1);
    add(1, P_CLR,         1,  0, 0, 24'h000005, 0, 0, 0, 0);
    add(1, P_RUN,         1,  0, 1, 24'h000005, 0, 0, 1, 0);
    add(1, '0,            0,  2, 0, 24'h000003, 0, 0, 1, 0);
    add(1, P_RUN,         1,  0, 1, 24'h000003, 0, 0, 0, 0);
    add(1, P_RUN | P_CLR, 1,  0, 0, 24'h000005, 0, 0, 0, 0);
    add(0, P_SEL | P_FLD | P_INC | P_RUN,
                          2,  0, 0, 24'h000005, 0, 0, 0, 0);
    add(1, P_SEL,         2,  0, 0, 24'h000000, 2, 0, 0, 0);
    add(1, P_RUN,         1,  0, 0, 24'h000000, 2, 0, 0, 0);
    add(1, '0,            0,  2, 0, 24'h000000, 2, 0, 0, 0);

    model_reset();
    tcnt = 0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_data", disp_data, 24'h0);
    chk("rst_chan", disp_chan, 2'd0);
    chk("rst_field", edit_field, 2'd0);
    chk("rst_running", running, 4'h0);
    chk("rst_alarm", alarm, 4'h0);

    foreach (tbl[i]) begin
      tcnt = 0;
      if (tbl[i].align)
        for (int k = 0; k < HZ && ppos != 0; k++)
          step(tbl[i].act, '0);
      for (int k = 0; k < tbl[i].reps; k++)
        step(tbl[i].act, tbl[i].p);
      for (int k = 0; k < HZ * (tbl[i].ticks + 1) && tcnt < tbl[i].ticks; k++)
        step(tbl[i].act, '0);
      if (tcnt < tbl[i].ticks) begin
        total++;
        bad++;
        $display("FAIL v%0d tick wait expired got=%0d exp=%0d",
                 i, tcnt, tbl[i].ticks);
      end
      chk($sformatf("v%0d_data", i), disp_data, tbl[i].d);
      chk($sformatf("v%0d_chan", i), disp_chan, tbl[i].ch);
      chk($sformatf("v%0d_field", i), edit_field, tbl[i].fl);
      chk($sformatf("v%0d_running", i), running, tbl[i].r);
      chk($sformatf("v%0d_alarm", i), alarm, tbl[i].a);
    end

    // run pulse on the same edge as a second tick: pause, no decrement
    step(1'b1, P_SEL);
    step(1'b1, P_SEL);
    chk("a_chan", disp_chan, 2'd0);
    step(1'b1, P_RUN);
    chk("a_running", running, 4'b0001);
    for (int k = 0; k < HZ && ppos != HZ - 1; k++)
      step(1'b1, '0);
    step(1'b1, P_RUN);
    chk("a_coinc_data", disp_data, 24'h000005);
    chk("a_coinc_running", running, 4'b0000);
    wait_ticks("a_hold", 2);
    chk("a_hold_data", disp_data, 24'h000005);

    // asynchronous reset in the middle of a countdown
    step(1'b1, P_RUN);
    chk("b_running", running, 4'b0001);
    step(1'b1, P_SEL);
    step(1'b1, P_FLD);
    chk("b_chan", disp_chan, 2'd1);
    chk("b_field", edit_field, 2'd1);
    reset = 1'b1;
    #1;
    chk("b_rst_running", running, 4'h0);
    chk("b_rst_alarm", alarm, 4'h0);
    chk("b_rst_chan", disp_chan, 2'd0);
    chk("b_rst_field", edit_field, 2'd0);
    chk("b_rst_data", disp_data, 24'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();

    // random pulses against the reference model
    for (int n = 0; n < 3000; n++) begin
      logic a;
      logic [4:0] p;
      a = ($urandom_range(0, 9) != 0);
      p[4] = ($urandom_range(0, 15) == 0);
      p[3] = ($urandom_range(0, 31) == 0);
      p[2] = ($urandom_range(0, 3) == 0);
      p[1] = ($urandom_range(0, 11) == 0);
      p[0] = ($urandom_range(0, 39) == 0);
      step(a, p);
      model_check(n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_timer.md
Name: multi_timer

Overview:
- Bank of CHANNELS independent HH:MM:SS countdown timers with per-channel preset, pause, and a self-clearing alarm.
- Next-generation replacement for the single-channel timer under the clock top level.
- Consumes one-cycle debounced button pulses and a mode-active flag.
- Presents the selected channel's BCD time to the 7-segment display mux, plus per-channel run/alarm flags for LEDs.

Parameters:
- CHANNELS, 4, number of timer channels (1..16).
- CLK_HZ, 50_000_000, clock cycles per second tick.
- ALARM_SECS, 10, seconds an alarm stays asserted before auto-clearing.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- active  in  1  timer mode selected; all pulses ignored when low
- sel_pulse  in  1  advance selected channel
- field_pulse  in  1  advance edit field S->M->H->S
- inc_pulse  in  1  increment edit field of selected channel
- run_pulse  in  1  start/pause/acknowledge selected channel
- clr_pulse  in  1  reload preset, return selected channel to IDLE
- disp_data  out  24  selected channel BCD {HH,MM,SS}
- disp_chan  out  $clog2(CHANNELS) (min 1)  selected channel index
- edit_field  out  2  0=S, 1=M, 2=H
- running  out  CHANNELS  channel in RUN
- alarm  out  CHANNELS  channel in ALARM

Behaviour:
- Reset values: all channels IDLE with preset = count = 00:00:00; disp_chan=0; edit_field=0; running=0; alarm=0; prescaler=0.
- Prescaler:
  - Counts 0..CLK_HZ-1 and emits a one-cycle sec_tick at wrap.
  - Free-running, shared by all channels, unaffected by active.
- Pulse gating: pulses act only when active=1, and only on the channel held in disp_chan at that cycle. sel_pulse takes effect next cycle.
- Pulse priority (one action per cycle): clr > run > inc > field. sel_pulse is independent and is always honoured alongside the winner.
- disp_chan wraps CHANNELS-1 -> 0. edit_field wraps 2 -> 0.
- Per-channel FSM, states IDLE, RUN, PAUSE, ALARM:
  - IDLE:
    - inc adds 1 to the field in BCD, writing both preset and count. S and M wrap 59->00; H wraps 23->00; no carry between fields.
    - run: if count != 0 -> RUN; if count == 0 the pulse is ignored.
  - RUN:
    - sec_tick decrements count in BCD with borrow (SS 00->59 borrows M; MM 00->59 borrows H).
    - A tick taking count 00:00:01 -> 00:00:00 enters ALARM on the same edge.
    - run -> PAUSE. inc ignored.
  - PAUSE:
    - Count frozen. run -> RUN. inc edits count only (preset unchanged).
  - ALARM:
    - Count = 0. Alarm counter loads ALARM_SECS and decrements per sec_tick.
    - run or clr, or alarm counter reaching 0: reload count from preset -> IDLE.
  - clr in any state: count <= preset, -> IDLE.
- Simultaneous sec_tick and run on a RUN channel: pause wins; no decrement that cycle.
- Non-selected channels keep counting and alarming independently.
- Outputs:
  - disp_data is a combinational mux of registered counts.
  - running and alarm are decoded from registered state, so they change on the clock edge after the transition-causing input.
- Reset mid-operation: immediate return to reset values. No preset retention.
- All BCD digits stay legal; the RTL never produces A-F.

Decomposition:
- Package multi_timer_pkg:
  - enum timer_state_t {IDLE, RUN, PAUSE, ALARM}
  - enum field_t {F_SEC, F_MIN, F_HOUR}
  - struct bcd_time_t {h, m, s} of 8 bits each
  - constants BCD_59 = 8'h59, BCD_23 = 8'h23
  - functions bcd_inc_wrap and bcd_dec_borrow
- Sub-module timer_channel: one FSM, preset/count registers and alarm counter. Instantiated CHANNELS times in a generate loop.
- Prescaler, selection and field logic stay in multi_timer.

Test Plan (CLK_HZ=4, ALARM_SECS=3, CHANNELS=4):
- Edit: reset; active=1; field_pulse x2 (H); inc x25 -> disp_data 24'h010000. field_pulse (S); inc x60 -> SS wraps to 00, disp_data 24'h010000.
- Borrow: ch0 preset 00:01:00, run -> running[0]=1; after 1 tick disp_data 24'h000059; at 60 ticks alarm[0]=1, running[0]=0.
- Alarm timeout: continue 3 ticks -> alarm[0]=0, ch0 IDLE, disp_data 24'h000100 (preset reloaded). Repeat with a run_pulse during ALARM -> same result immediately.
- Independence: ch0 RUN at 00:00:05; sel_pulse to ch1; 5 ticks elapse -> alarm[0]=1 while disp_chan=1 and disp_data shows ch1 value.
- Priority and gating:
  - clr_pulse+run_pulse same cycle on PAUSE channel -> IDLE with preset.
  - sec_tick coincident with run on RUN channel -> PAUSE, count unchanged.
  - active=0 with pulses -> no state change.
- Zero start and reset: run_pulse on IDLE 00:00:00 -> stays IDLE. Assert reset mid-RUN -> all outputs zero within same cycle (async).
